instruction_sequencer: RTL and testbench
========================================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 CLR  input  1  reset, synchronous, active-high.
REQ-004 state  input  18  one-hot T-state from the ring counter; bit 0 = T1 ... bit 17 = T18.
REQ-005 opcode  input  8  instruction register contents; valid from T4 onward.
REQ-006 cond_met  input  1  flag condition for JM/JNZ/JZ; sampled at T4.
REQ-007 ring_nclr  output  1  active-low restart to the ring counter; low forces T1 at the next edge.
REQ-008 t_index  output  5  registered binary T-state number, 1..18; 0 = invalid.
REQ-009 halt  output  1  sticky; HLT executed.
REQ-010 err  output  2  sticky; bit0 = non-one-hot state, bit1 = undefined opcode.
REQ-011 instr_count  output  CNT_W  number of completed instructions.

Function
REQ-012 The block SHALL decode the state index combinationally: the single set bit position plus 1, or 0 if zero bits or more than one bit is set.
REQ-013 t_index SHALL equal the previous cycle's decoded index (1-cycle latency).
REQ-014 In T4 the block SHALL register the opcode and its instruction length L, taken from the table below; outside T4, L SHALL hold.
REQ-015 Length table (hex opcode:L): 80,81,A0,A1,B0,B1,A8,A9,2F,3D,0D,05,3C,0C,04,78,79,7A,47,4F,41,48,00:4; 3E,06,0E:7; C3,C9:10; FA,C2,CA:10 if cond_met else 7; 3A,32:13; CD:18; 76:5.
REQ-016 Any opcode not in the table SHALL use L=4 (executes as NOP) and SHALL set err[1] at T4.
REQ-017 The effective length SHALL be the table value of the live opcode during T4, and the registered L otherwise.
REQ-018 ring_nclr (combinational) SHALL be low when the decoded index equals the effective length, when halt=1, or when the decoded index is 0; otherwise high.
REQ-019 When ring_nclr is low due to an index match, instr_count SHALL increment by 1 at that edge, wrapping from 2^CNT_W-1 to 0.
REQ-020 For opcode 76 at T5, halt SHALL set at the edge; instr_count SHALL increment once. While halt=1, ring_nclr SHALL stay low and instr_count SHALL freeze.
REQ-021 A decoded index of 0 SHALL set err[0] at that edge and SHALL NOT increment instr_count.
REQ-022 Per-instruction state (registered opcode and L) SHALL be overwritten at every T4; no state carries across instructions.
REQ-023 If a decoded index exceeds L, the block SHALL take no restart action; the ring wraps naturally at T18.

Reset
REQ-024 CLR=1 at an edge SHALL clear t_index, halt, err, instr_count and the registered opcode, and SHALL set L to 4.
REQ-025 CLR SHALL have priority over every simultaneous event (halt set, err set, count increment).
REQ-026 During CLR=1, ring_nclr SHALL follow REQ-018 using the reset values.
REQ-027 CLR asserted mid-instruction SHALL abandon that instruction and SHALL NOT count it.

Verification
REQ-028 Opcode 80, ring T1..T4 -> ring_nclr low only during T4; instr_count 0->1; t_index = 1,2,3,4 one cycle late.
REQ-029 Opcode CD -> ring_nclr high T1..T17, low at T18; instr_count +1; next state T1.
REQ-030 Opcode CA: with cond_met=0 -> restart at T7; with cond_met=1 -> restart at T10.
REQ-031 Opcode 76 -> restart at T5, halt=1 from the next cycle; ring_nclr held low; instr_count frozen; CLR -> halt=0, count=0.
REQ-032 state=0x00000, then 0x00003 -> err[0]=1, ring_nclr low, t_index=0; opcode FF at T4 -> err[1]=1, restart at T4.
REQ-033 CLR asserted at T8 of opcode 3A -> no count; registered L=4; outputs at reset values next cycle.

Source files
------------

// File: rtl/instruction_sequencer.sv
// ============================================================================
// Module   : instruction_sequencer
// Purpose  : T-state decode, per-opcode instruction length and ring restart.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [17:0]      state,
  input  logic [7:0]       opcode,
  input  logic             cond_met,
  output logic             ring_nclr,
  output logic [4:0]       t_index,
  output logic             halt,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [4:0] c_LEN_RST = 5'd4;

  logic [4:0]       w_ones;
  logic [4:0]       w_pos;
  logic [4:0]       w_idx;
  logic [4:0]       w_len_live;
  logic             w_undef;
  logic [4:0]       w_len_reg;
  logic [4:0]       w_eff_len;
  logic             w_halt_eff;
  logic             w_match;

  logic [4:0]       r_t_index;
  logic             r_halt;
  logic [1:0]       r_err;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_op;
  logic [4:0]       r_len;

  always_comb begin
    w_ones = 5'd0;
    w_pos  = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (state[i]) begin
        w_ones = w_ones + 5'd1;
        w_pos  = 5'(i + 1);
      end
    end
    w_idx = (w_ones == 5'd1) ? w_pos : 5'd0;
  end

  always_comb begin
    w_len_live = 5'd4;
    w_undef    = 1'b0;
    case (opcode)
      8'h80, 8'h81, 8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA8, 8'hA9,
      8'h2F, 8'h3D, 8'h0D, 8'h05, 8'h3C, 8'h0C, 8'h04, 8'h78,
      8'h79, 8'h7A, 8'h47, 8'h4F, 8'h41, 8'h48, 8'h00:
        w_len_live = 5'd4;
      8'h3E, 8'h06, 8'h0E:        w_len_live = 5'd7;
      8'hC3, 8'hC9:               w_len_live = 5'd10;
      8'hFA, 8'hC2, 8'hCA:        w_len_live = cond_met ? 5'd10 : 5'd7;
      8'h3A, 8'h32:               w_len_live = 5'd13;
      8'hCD:                      w_len_live = 5'd18;
      8'h76:                      w_len_live = 5'd5;
      default: begin
        w_len_live = 5'd4;
        w_undef    = 1'b1;
      end
    endcase
  end

  // While CLR is high the restart decision already sees post-reset halt and L.
  assign w_len_reg  = CLR ? c_LEN_RST : r_len;
  assign w_halt_eff = r_halt & ~CLR;
  assign w_eff_len  = (w_idx == 5'd4) ? w_len_live : w_len_reg;
  assign w_match    = (w_idx != 5'd0) && (w_idx == w_eff_len);
  assign ring_nclr  = ~(w_match | w_halt_eff | (w_idx == 5'd0));

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_t_index <= 5'd0;
      r_halt    <= 1'b0;
      r_err     <= 2'b00;
      r_count   <= '0;
      r_op      <= 8'h00;
      r_len     <= c_LEN_RST;
    end else begin
      r_t_index <= w_idx;
      if (w_idx == 5'd4) begin
        r_op  <= opcode;
        r_len <= w_len_live;
        if (w_undef) r_err[1] <= 1'b1;
      end
      if (w_idx == 5'd0) r_err[0] <= 1'b1;
      if (w_match && !r_halt) r_count <= r_count + 1'b1;
      if (r_op == 8'h76 && w_idx == 5'd5) r_halt <= 1'b1;
    end
  end

  assign t_index     = r_t_index;
  assign halt        = r_halt;
  assign err         = r_err;
  assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
// ============================================================================
// Module   : tb_instruction_sequencer
// Purpose  : Directed and randomized checks against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_sequencer;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          CLR = 1'b1;
  logic [17:0]   st = 18'd1;
  logic [7:0]    op = 8'h00;
  logic          cond = 1'b0;
  logic          ring_nclr;
  logic [4:0]    t_index;
  logic          halt;
  logic [1:0]    err;
  logic [CW-1:0] instr_count;

  int n_pass = 0;
  int n_chk  = 0;

  // behavioural model state
  int   m_len, m_cnt, m_tidx;
  bit   m_halt;
  bit [1:0] m_err;
  bit [7:0] m_op;
  bit   exp_nclr;

  instruction_sequencer #(.CNT_W(CW)) dut (
    .CLK(CLK), .CLR(CLR), .state(st), .opcode(op), .cond_met(cond),
    .ring_nclr(ring_nclr), .t_index(t_index), .halt(halt), .err(err),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [17:0] oh(input int t);
    logic [17:0] one;
    one = 18'd1;
    return one << (t - 1);
  endfunction

  function automatic int f_idx(input logic [17:0] v);
    if ($countones(v) != 1) return 0;
    for (int i = 0; i < 18; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  // 0 means "not in the table"
  function automatic int f_len(input logic [7:0] o, input logic c);
    case (o)
      8'h80, 8'h81, 8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA8, 8'hA9, 8'h2F, 8'h3D,
      8'h0D, 8'h05, 8'h3C, 8'h0C, 8'h04, 8'h78, 8'h79, 8'h7A, 8'h47, 8'h4F,
      8'h41, 8'h48, 8'h00: return 4;
      8'h3E, 8'h06, 8'h0E: return 7;
      8'hC3, 8'hC9:        return 10;
      8'hFA, 8'hC2, 8'hCA: return c ? 10 : 7;
      8'h3A, 8'h32:        return 13;
      8'hCD:               return 18;
      8'h76:               return 5;
      default:             return 0;
    endcase
  endfunction

  function automatic int eff_len();
    int l;
    if (f_idx(st) == 4) begin
      l = f_len(op, cond);
      return (l == 0) ? 4 : l;
    end
    return CLR ? 4 : m_len;
  endfunction

  function automatic bit model_nclr();
    int idx;
    idx = f_idx(st);
    return !(idx == 0 || idx == eff_len() || (m_halt && !CLR));
  endfunction

  task automatic model_tick();
    int idx, e;
    idx = f_idx(st);
    e = eff_len();
    if (CLR) begin
      m_len = 4; m_cnt = 0; m_tidx = 0; m_halt = 0; m_err = 0; m_op = 0;
    end else begin
      if (idx != 0 && idx == e && !m_halt) m_cnt = (m_cnt + 1) % (1 << CW);
      if (m_op == 8'h76 && idx == 5) m_halt = 1;
      if (idx == 0) m_err[0] = 1;
      if (idx == 4) begin
        m_op  = op;
        m_len = e;
        if (f_len(op, cond) == 0) m_err[1] = 1;
      end
      m_tidx = idx;
    end
  endtask

  task automatic apply(input logic [17:0] v, input logic [7:0] o, input logic c, input logic clr);
    @(negedge CLK);
    st = v; op = o; cond = c; CLR = clr;
    exp_nclr = model_nclr();
    #1;
  endtask

  task automatic clock();
    @(posedge CLK);
    model_tick();
    #1;
  endtask

  task automatic do_clr();
    apply(oh(1), 8'h00, 1'b0, 1'b1);
    clock();
  endtask

  task automatic test_reset();
    apply(oh(1), 8'h80, 1'b0, 1'b1);
    n_chk++; if (ring_nclr !== 1'b1) $display("FAIL reset_nclr got=%b exp=1", ring_nclr); else n_pass++;
    clock();
    n_chk++; if (t_index !== 5'd0) $display("FAIL reset_tidx got=%0d exp=0", t_index); else n_pass++;
    n_chk++; if ({halt, err} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {halt, err}); else n_pass++;
    n_chk++; if (instr_count !== '0) $display("FAIL reset_cnt got=%0d exp=0", instr_count); else n_pass++;
  endtask

  task automatic test_op80();
    do_clr();
    for (int t = 1; t <= 4; t++) begin
      apply(oh(t), 8'h80, 1'b0, 1'b0);
      n_chk++; if (ring_nclr !== (t != 4)) $display("FAIL op80_nclr T%0d got=%b", t, ring_nclr); else n_pass++;
      clock();
      n_chk++; if (t_index !== 5'(t)) $display("FAIL op80_tidx got=%0d exp=%0d", t_index, t); else n_pass++;
    end
    n_chk++; if (instr_count !== 4'd1) $display("FAIL op80_cnt got=%0d exp=1", instr_count); else n_pass++;
  endtask

  task automatic test_cd();
    int low_at;
    do_clr();
    low_at = 0;
    for (int t = 1; t <= 18; t++) begin
      apply(oh(t), 8'hCD, 1'b0, 1'b0);
      if (ring_nclr === 1'b0 && low_at == 0) low_at = t;
      clock();
    end
    n_chk++; if (low_at != 18) $display("FAIL cd_restart got=T%0d exp=T18", low_at); else n_pass++;
    n_chk++; if (instr_count !== 4'd1) $display("FAIL cd_cnt got=%0d exp=1", instr_count); else n_pass++;
  endtask

  task automatic test_cond();
    int low_at;
    for (int c = 0; c < 2; c++) begin
      do_clr();
      low_at = 0;
      for (int t = 1; t <= 12 && low_at == 0; t++) begin
        // flip cond after T4 to show it is sampled only at T4
        apply(oh(t), 8'hCA, (t > 4) ? logic'(c == 0) : logic'(c), 1'b0);
        if (ring_nclr === 1'b0) low_at = t;
        clock();
      end
      n_chk++; if (low_at != (c ? 10 : 7)) $display("FAIL ca_cond%0d got=T%0d exp=T%0d", c, low_at, c ? 10 : 7); else n_pass++;
    end
  endtask

  task automatic test_halt();
    do_clr();
    for (int t = 1; t <= 5; t++) begin
      apply(oh(t), 8'h76, 1'b0, 1'b0);
      if (t == 5) begin
        n_chk++; if (ring_nclr !== 1'b0) $display("FAIL hlt_t5_nclr got=%b exp=0", ring_nclr); else n_pass++;
      end
      clock();
    end
    n_chk++; if (halt !== 1'b1) $display("FAIL hlt_set got=%b exp=1", halt); else n_pass++;
    n_chk++; if (instr_count !== 4'd1) $display("FAIL hlt_cnt got=%0d exp=1", instr_count); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      apply(oh(1), 8'h76, 1'b0, 1'b0);
      n_chk++; if (ring_nclr !== 1'b0) $display("FAIL hlt_hold_nclr got=%b exp=0", ring_nclr); else n_pass++;
      clock();
    end
    n_chk++; if (instr_count !== 4'd1) $display("FAIL hlt_freeze got=%0d exp=1", instr_count); else n_pass++;
    apply(oh(1), 8'h00, 1'b0, 1'b1);
    n_chk++; if (ring_nclr !== 1'b1) $display("FAIL hlt_clr_nclr got=%b exp=1", ring_nclr); else n_pass++;
    clock();
    n_chk++; if ({halt, instr_count} !== {1'b0, 4'd0}) $display("FAIL hlt_clr got=%b/%0d exp=0/0", halt, instr_count); else n_pass++;
  endtask

  task automatic test_err();
    do_clr();
    apply(18'h00000, 8'h00, 1'b0, 1'b0);
    n_chk++; if (ring_nclr !== 1'b0) $display("FAIL err_zero_nclr got=%b exp=0", ring_nclr); else n_pass++;
    clock();
    n_chk++; if ({err, t_index} !== {2'b01, 5'd0}) $display("FAIL err_zero got=%b/%0d exp=01/0", err, t_index); else n_pass++;
    apply(18'h00003, 8'h00, 1'b0, 1'b0);
    n_chk++; if (ring_nclr !== 1'b0) $display("FAIL err_multi_nclr got=%b exp=0", ring_nclr); else n_pass++;
    clock();
    n_chk++; if ({err, t_index, instr_count} !== {2'b01, 5'd0, 4'd0}) $display("FAIL err_multi got=%b/%0d/%0d exp=01/0/0", err, t_index, instr_count); else n_pass++;
    do_clr();
    for (int t = 1; t <= 4; t++) begin
      apply(oh(t), 8'hFF, 1'b0, 1'b0);
      n_chk++; if (ring_nclr !== (t != 4)) $display("FAIL err_ff_nclr T%0d got=%b", t, ring_nclr); else n_pass++;
      clock();
    end
    n_chk++; if ({err, instr_count} !== {2'b10, 4'd1}) $display("FAIL err_undef got=%b/%0d exp=10/1", err, instr_count); else n_pass++;
  endtask

  task automatic test_clr_mid();
    do_clr();
    for (int t = 1; t <= 4; t++) begin apply(oh(t), 8'h80, 1'b0, 1'b0); clock(); end
    for (int t = 1; t <= 7; t++) begin apply(oh(t), 8'h3A, 1'b0, 1'b0); clock(); end
    apply(oh(8), 8'h3A, 1'b0, 1'b1);
    clock();
    n_chk++; if ({t_index, halt, err, instr_count} !== {5'd0, 1'b0, 2'b00, 4'd0}) $display("FAIL clrmid_regs got=%0d/%b/%b/%0d exp=0/0/00/0", t_index, halt, err, instr_count); else n_pass++;
    apply(oh(13), 8'h3A, 1'b0, 1'b0);
    n_chk++; if (ring_nclr !== 1'b1) $display("FAIL clrmid_len got=%b exp=1", ring_nclr); else n_pass++;
    clock();
  endtask

  task automatic test_random();
    logic [7:0] pool [0:9];
    int t, r;
    logic [7:0] cur;
    logic [17:0] v;
    logic clr;
    pool = '{8'h80, 8'h3E, 8'hC3, 8'hFA, 8'hC2, 8'h32, 8'hCD, 8'h76, 8'h47, 8'h0E};
    do_clr();
    t = 1;
    cur = 8'h00;
    for (int k = 0; k < 1500; k++) begin
      if (t == 1) cur = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      r = $urandom_range(0, 99);
      clr = (r < 2);
      if (r >= 2 && r < 4)      v = 18'($urandom);
      else if (r >= 4 && r < 6) v = oh($urandom_range(1, 18));
      else                      v = oh(t);
      apply(v, cur, 1'($urandom), clr);
      n_chk++; if (ring_nclr !== exp_nclr) $display("FAIL rnd_nclr k=%0d got=%b exp=%b", k, ring_nclr, exp_nclr); else n_pass++;
      clock();
      n_chk++;
      if ({t_index, halt, err, instr_count} !== {5'(m_tidx), m_halt, m_err, 4'(m_cnt)})
        $display("FAIL rnd_regs k=%0d got=%0d/%b/%b/%0d exp=%0d/%b/%b/%0d", k, t_index, halt, err, instr_count, m_tidx, m_halt, m_err, m_cnt);
      else n_pass++;
      t = (clr || !exp_nclr || f_idx(v) == 0 || f_idx(v) == 18) ? 1 : f_idx(v) + 1;
    end
  endtask

  initial begin
    m_len = 4; m_cnt = 0; m_tidx = 0; m_halt = 0; m_err = 0; m_op = 0; exp_nclr = 1;
    test_reset();
    test_op80();
    test_cd();
    test_cond();
    test_halt();
    test_err();
    test_clr_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
